// File: rtl/spectrum_bar_decay.sv
// Per-bin spectrum bar with gravity decay and peak-hold marker, one RAM read-modify-write per sample.
// Optional post-reset / on-demand RAM clear sweep enabled by defining SPC_BAR_CLEAR_EN.
module spectrum_bar_decay #(
   parameter int NUM_BINS    = 64,
   parameter int BIN_BITS    = 6,
   parameter int DECAY_STEP  = 2,
   parameter int HOLD_FRAMES = 16,
   parameter int HOLD_BITS   = 5
) (
   input  logic                Clock,
   input  logic                Reset,
`ifdef SPC_BAR_CLEAR_EN
   input  logic                Clear,
`endif
   input  logic                FrameStart,
   input  logic                InValid,
   input  logic [6:0]          InLevel,
   output logic                Busy,
   output logic                WrEn,
   output logic [BIN_BITS-1:0] WrAddr,
   output logic [6:0]          WrBar,
   output logic [6:0]          WrPeak,
   output logic                FrameDone,
   output logic                Overrun
);

   localparam logic [BIN_BITS-1:0] LAST_BIN = BIN_BITS'(NUM_BINS - 1);

   typedef struct packed {
      logic [6:0]           bar;
      logic [6:0]           peak;
      logic [HOLD_BITS-1:0] hold;
   } entry_t;

   typedef enum logic [1:0] {
      IDLE,
      READ,
      WRITE
`ifdef SPC_BAR_CLEAR_EN
      , CLEAR
`endif
   } state_t;

   state_t              state, state_nxt;
   logic [BIN_BITS-1:0] bin_cnt, lat_addr, rd_addr;
   logic [6:0]          lat_level;
   logic                fs_pend, overrun_q;
   logic                accept, clear_go, in_clear, clear_last;
   entry_t              rd_data, upd, res, wr_entry;
   logic [6:0]          bar_dec, peak_dec;

   entry_t mem [NUM_BINS];

`ifdef SPC_BAR_CLEAR_EN
   logic [BIN_BITS-1:0] clr_addr;
   logic                sweep_req;

   assign clear_go   = (state == IDLE) && (Clear || sweep_req);
   assign in_clear   = (state == CLEAR);
   assign clear_last = in_clear && (clr_addr == LAST_BIN);

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         clr_addr  <= '0;
         sweep_req <= 1'b1;
      end else begin
         if (clear_go)
            sweep_req <= 1'b0;
         if (in_clear)
            clr_addr <= clr_addr + BIN_BITS'(1);
         else
            clr_addr <= '0;
      end
   end
`else
   assign clear_go   = 1'b0;
   assign in_clear   = 1'b0;
   assign clear_last = 1'b0;
`endif

   assign accept  = (state == IDLE) && InValid && !clear_go;
   // FrameStart coincident with InValid makes that very sample bin 0.
   assign rd_addr = FrameStart ? '0 : bin_cnt;

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      state_nxt = state;
      case (state)
         IDLE: begin
`ifdef SPC_BAR_CLEAR_EN
            if (clear_go)
               state_nxt = CLEAR;
            else
`endif
            if (InValid)
               state_nxt = READ;
         end
         READ:  state_nxt = WRITE;
         WRITE: state_nxt = IDLE;
`ifdef SPC_BAR_CLEAR_EN
         CLEAR: if (clear_last) state_nxt = IDLE;
`endif
         default: state_nxt = IDLE;
      endcase
   end

   // Bar/peak update from the word read back for the latched bin.
   always_comb begin
      upd      = rd_data;
      bar_dec  = (rd_data.bar >= 7'(DECAY_STEP)) ? rd_data.bar - 7'(DECAY_STEP) : '0;
      peak_dec = (rd_data.peak != '0) ? rd_data.peak - 7'd1 : '0;
      if (lat_level >= rd_data.bar)
         upd.bar = lat_level;
      else
         upd.bar = (lat_level > bar_dec) ? lat_level : bar_dec;
      if (lat_level >= rd_data.peak) begin
         upd.peak = lat_level;
         upd.hold = HOLD_BITS'(HOLD_FRAMES);
      end else if (rd_data.hold != '0) begin
         upd.hold = rd_data.hold - HOLD_BITS'(1);
      end else begin
         upd.peak = (upd.bar > peak_dec) ? upd.bar : peak_dec;
         upd.hold = '0;
      end
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         bin_cnt   <= '0;
         lat_addr  <= '0;
         lat_level <= '0;
         fs_pend   <= 1'b0;
         overrun_q <= 1'b0;
         res       <= '0;
      end else begin
         if (accept) begin
            lat_addr  <= rd_addr;
            lat_level <= InLevel;
         end
         if (state == READ)
            res <= upd;
         if (InValid && ((state != IDLE) || clear_go))
            overrun_q <= 1'b1;

         // A FrameStart seen mid-transaction only takes effect once the in-flight write lands.
         if (state == WRITE) begin
            fs_pend <= 1'b0;
            if (FrameStart || fs_pend || (lat_addr == LAST_BIN))
               bin_cnt <= '0;
            else
               bin_cnt <= lat_addr + BIN_BITS'(1);
         end else if (clear_last) begin
            bin_cnt <= '0;
         end else if (state == READ) begin
            if (FrameStart)
               fs_pend <= 1'b1;
         end else if ((state == IDLE) && FrameStart && !accept) begin
            bin_cnt <= '0;
         end
      end
   end

   assign Busy      = (state != IDLE);
   assign WrEn      = (state == WRITE) || in_clear;
`ifdef SPC_BAR_CLEAR_EN
   assign WrAddr    = in_clear ? clr_addr : lat_addr;
`else
   assign WrAddr    = lat_addr;
`endif
   assign wr_entry  = in_clear ? '0 : res;
   assign WrBar     = wr_entry.bar;
   assign WrPeak    = wr_entry.peak;
   assign FrameDone = (state == WRITE) && (lat_addr == LAST_BIN);
   assign Overrun   = overrun_q;

   // NOTE: the state RAM has no reset; bar/peak history survives Reset by design.
   always_ff @(posedge Clock) begin
      if (WrEn)
         mem[WrAddr] <= wr_entry;
      if (accept)
         rd_data <= mem[rd_addr];
   end

endmodule

// File: tb/tb_spectrum_bar_decay.sv
// Directed self-checking bench for spectrum_bar_decay (default build, no clear sweep).
// Expected values are hand-derived from the bar/peak rules; the state RAM powers up zeroed.
module tb_spectrum_bar_decay;

   logic       Clock = 1'b0;
   logic       Reset = 1'b0;
   logic       FrameStart = 1'b0;
   logic       InValid = 1'b0;
   logic [6:0] InLevel = '0;
   logic       Busy, WrEn, FrameDone, Overrun;
   logic [5:0] WrAddr;
   logic [6:0] WrBar, WrPeak;

   int n_cmp = 0;
   int n_bad = 0;

   spectrum_bar_decay dut (
      .Clock      (Clock),
      .Reset      (Reset),
      .FrameStart (FrameStart),
      .InValid    (InValid),
      .InLevel    (InLevel),
      .Busy       (Busy),
      .WrEn       (WrEn),
      .WrAddr     (WrAddr),
      .WrBar      (WrBar),
      .WrPeak     (WrPeak),
      .FrameDone  (FrameDone),
      .Overrun    (Overrun)
   );

   always #5 Clock = ~Clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // One sample with minimum spacing; checks the write two cycles after the pulse.
   task automatic sample(input string tag, input logic [6:0] lvl, input logic fs,
                         input int addr, input int bar, input int peak, input logic done);
      @(negedge Clock);
      InValid = 1'b1; InLevel = lvl; FrameStart = fs;
      @(negedge Clock);
      InValid = 1'b0; FrameStart = 1'b0;
      @(negedge Clock);
      check({tag, ".wren"}, WrEn, 1);
      check({tag, ".addr"}, WrAddr, addr);
      check({tag, ".bar"},  WrBar, bar);
      check({tag, ".peak"}, WrPeak, peak);
      check({tag, ".done"}, FrameDone, done);
   endtask

   initial begin
      int wr_cnt;
      int wr_addr;

      #1 Reset = 1'b1;
      repeat (2) @(negedge Clock);
      check("rst.busy", Busy, 0);
      check("rst.wren", WrEn, 0);
      check("rst.addr", WrAddr, 0);
      check("rst.bar",  WrBar, 0);
      check("rst.peak", WrPeak, 0);
      check("rst.done", FrameDone, 0);
      check("rst.ovr",  Overrun, 0);
      Reset = 1'b0;
      @(negedge Clock);

      // Single sample into zeroed RAM, with exact latency.
      @(negedge Clock);
      InValid = 1'b1; InLevel = 7'd100; FrameStart = 1'b1;
      @(negedge Clock);
      InValid = 1'b0; FrameStart = 1'b0;
      check("single.busy", Busy, 1);
      check("single.early", WrEn, 0);
      @(negedge Clock);
      check("single.wren", WrEn, 1);
      check("single.addr", WrAddr, 0);
      check("single.bar",  WrBar, 100);
      check("single.peak", WrPeak, 100);
      @(negedge Clock);
      check("single.idle", Busy, 0);

      // Decay and peak release on bin 0: bar falls 2/frame, peak held 16 frames then falls 1/frame.
      for (int k = 1; k <= 24; k++) begin
         sample($sformatf("decay%0d", k), 7'd0, 1'b1, 0, 100 - 2 * k,
                (k <= 16) ? 100 : 100 - (k - 16), 1'b0);
         check($sformatf("decay%0d.inv", k), (WrPeak >= WrBar), 1);
      end

      // Saturation: bin 1 bar=1 fed 0 must reach 0, not wrap.
      sample("sat.b0a", 7'd127, 1'b1, 0, 127, 127, 1'b0);
      sample("sat.b1a", 7'd1,   1'b0, 1, 1,   1,   1'b0);
      sample("sat.b0b", 7'd127, 1'b1, 0, 127, 127, 1'b0);
      sample("sat.b1b", 7'd0,   1'b0, 1, 0,   1,   1'b0);

      // Full frame: addresses 0..63, FrameDone only on 63, then wrap to 0.
      for (int i = 0; i < 64; i++)
         sample($sformatf("wrap%0d", i), 7'd127, (i == 0), i, 127, 127, (i == 63));
      sample("wrap64", 7'd127, 1'b0, 0, 127, 127, 1'b0);
      // Level just below bar beats the decayed bar; peak held.
      sample("near", 7'd126, 1'b0, 1, 126, 127, 1'b0);

      // FrameStart during READ: in-flight sample keeps bin 2, next sample is bin 0.
      @(negedge Clock);
      InValid = 1'b1; InLevel = 7'd127;
      @(negedge Clock);
      InValid = 1'b0; FrameStart = 1'b1;
      @(negedge Clock);
      FrameStart = 1'b0;
      check("fsread.wren", WrEn, 1);
      check("fsread.addr", WrAddr, 2);
      check("fsread.bar",  WrBar, 127);
      sample("fsread.next", 7'd127, 1'b0, 0, 127, 127, 1'b0);

      // Overrun: back-to-back pulses, second dropped; bin 1 126/127 fed 50 -> 124/127.
      wr_cnt  = 0;
      wr_addr = -1;
      @(negedge Clock);
      InValid = 1'b1; InLevel = 7'd50;
      @(negedge Clock);
      InValid = 1'b1; InLevel = 7'd10;
      for (int c = 0; c < 6; c++) begin
         if (c == 1) InValid = 1'b0;
         if (WrEn) begin
            wr_cnt++;
            wr_addr = int'(WrAddr);
            check("ovr.bar", WrBar, 124);
         end
         @(negedge Clock);
      end
      check("ovr.writes", wr_cnt, 1);
      check("ovr.addr", wr_addr, 1);
      check("ovr.flag", Overrun, 1);
      repeat (5) @(negedge Clock);
      check("ovr.sticky", Overrun, 1);

      // Reset mid-operation: write abandoned, RAM kept (bin 0 stays 127/127/hold16).
      @(negedge Clock);
      InValid = 1'b1; InLevel = 7'd0; FrameStart = 1'b1;
      @(negedge Clock);
      InValid = 1'b0; FrameStart = 1'b0;
      #1 Reset = 1'b1;
      #1 check("midrst.busy", Busy, 0);
      check("midrst.ovr", Overrun, 0);
      @(negedge Clock);
      check("midrst.wren", WrEn, 0);
      Reset = 1'b0;
      sample("midrst.after", 7'd0, 1'b1, 0, 125, 127, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/spectrum_bar_decay.md
Name: spectrum_bar_decay

Overview:
- Sits directly downstream of the FFT result optimiser.
- Consumes one 7-bit log-scaled spectrum level per FFT bin, each qualified by that stage's end-of-conversion pulse.
- Keeps a per-bin bar level with gravity-style decay, plus a per-bin peak-hold marker.
- Writes the updated bar/peak pair for each bin to the display buffer write port.

Parameters:
- NUM_BINS, 64: bins per frame.
- BIN_BITS, 6: bin address width; 2^BIN_BITS >= NUM_BINS.
- DECAY_STEP, 2: bar fall per frame, in level units.
- HOLD_FRAMES, 16: frames a new peak is held before it starts to fall.
- HOLD_BITS, 5: hold counter width; must hold HOLD_FRAMES.

Ports:
- Clock  in  1  system clock.
- Reset  in  1  reset; asynchronous, active-high.
- FrameStart  in  1  one-cycle pulse; next accepted sample is bin 0.
- InValid  in  1  one-cycle pulse; InLevel is valid (upstream End).
- InLevel  in  7  log spectrum level, 0..127.
- Busy  out  1  read-modify-write or clear in progress.
- WrEn  out  1  one-cycle display-buffer write strobe.
- WrAddr  out  BIN_BITS  bin index for the write.
- WrBar  out  7  updated bar level.
- WrPeak  out  7  updated peak level.
- FrameDone  out  1  one-cycle pulse, coincident with WrEn of bin NUM_BINS-1.
- Overrun  out  1  sticky flag: an InValid pulse was dropped.

Behaviour:
- Reset values: Busy=0, WrEn=0, WrAddr=0, WrBar=0, WrPeak=0, FrameDone=0, Overrun=0; bin counter=0; FSM=IDLE.
- State RAM: NUM_BINS words of {bar[6:0], peak[6:0], hold[HOLD_BITS-1:0]}.
  - Synchronous read; write port internal.
  - Reset does not clear the RAM; configuration initialises it to zero.
- FSM:
  - IDLE: InValid -> latch InLevel and bin index, issue RAM read, go to READ, Busy=1.
  - READ: RAM data available -> compute new values -> go to WRITE.
  - WRITE: RAM write-back; WrEn=1 with WrAddr/WrBar/WrPeak; bin counter advances -> go to IDLE, Busy=0.
- Latency: InValid at cycle N -> WrEn at cycle N+2. Minimum InValid spacing is 3 cycles.
- InValid while Busy=1: sample dropped, Overrun set; Overrun clears only on Reset.
- Bar update, with L = InLevel:
  - L >= bar_old: bar_new = L.
  - Otherwise: bar_new = max(L, bar_old - DECAY_STEP), subtraction saturating at 0.
- Peak update:
  - L >= peak_old: peak_new = L, hold = HOLD_FRAMES.
  - Else if hold > 0: hold = hold - 1, peak unchanged.
  - Else: peak_new = max(bar_new, peak_old - 1), subtraction saturating at 0.
  - Invariant: WrPeak >= WrBar always.
- Bin counter:
  - Increments at each WRITE.
  - Wraps NUM_BINS-1 -> 0; FrameDone pulses on that write.
- FrameStart:
  - Forces the counter to 0 for the next accepted sample.
  - FrameStart and InValid in the same cycle: the sample is bin 0.
  - FrameStart during READ/WRITE: the in-flight sample keeps its latched index; the counter becomes 0 after that write.
- Reset mid-operation: FSM to IDLE immediately; the in-flight write is abandoned; RAM keeps its prior contents.

Optional Feature:
- Macro: SPC_BAR_CLEAR_EN.
- Defined:
  - Adds input port Clear (1 bit) and state CLEAR.
  - Clear=1 in IDLE, or the first cycle after Reset release, enters CLEAR.
  - CLEAR writes zero to all NUM_BINS words, one per cycle, Busy=1, WrEn=1 with WrBar=WrPeak=0 for each address.
  - Returns to IDLE and resets the bin counter to 0.
  - InValid during CLEAR is dropped and sets Overrun. Clear while Busy is ignored.
- Undefined: no Clear port, no CLEAR state, no post-reset sweep.

Test Plan:
- Single sample: FrameStart, then InValid with InLevel=100 into a zeroed RAM -> WrEn two cycles later, WrAddr=0, WrBar=100, WrPeak=100.
- Bar decay: bin 0 holds bar=100, peak=100, hold=16; feed InLevel=0 for 3 frames -> WrBar 98, 96, 94; WrPeak stays 100.
- Peak release: after 16 frames at InLevel=0 following a peak of 100 -> frame 17 WrPeak=99, then falls 1 per frame, never below WrBar.
- Saturation: bar=1, InLevel=0, DECAY_STEP=2 -> WrBar=0, no wrap to 127.
- Frame wrap: 64 samples at spacing 3 -> WrAddr 0..63, FrameDone only with addr 63; 65th sample -> WrAddr=0.
- Overrun: two InValid pulses 1 cycle apart -> second dropped, one WrEn only, Overrun=1 until Reset.
